// File: rtl/pipe_operand_feeder.sv
// Purpose: buffers operand sets {a,b,c,d} in a small FIFO and issues one per cycle to a fixed-latency pipeline.
// Latency: a pushed set issues at the earliest one edge after its push; res_valid follows out_issue by LAT edges.
// Backpressure: in_ready drops when the FIFO is full; hold stalls issue but never blocks pushes.
module pipe_operand_feeder #(
  parameter int N     = 10,
  parameter int DEPTH = 4,
  parameter int LAT   = 3,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_c,
  input  logic [N-1:0]  in_d,
  input  logic          hold,
  output logic [N-1:0]  out_a,
  output logic [N-1:0]  out_b,
  output logic [N-1:0]  out_c,
  output logic [N-1:0]  out_d,
  output logic          out_issue,
  output logic          res_valid,
  output logic [CW-1:0] count,
  output logic [15:0]   issue_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
  } op_set_t;

  op_set_t       mem_q [DEPTH];
  op_set_t       in_set;
  op_set_t       out_set_q, out_set_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_issue_q, out_issue_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;
  logic [LAT-1:0] res_sr_q;
  logic          push, pop;

  assign in_set = '{a: in_a, b: in_b, c: in_c, d: in_d};

  // In reset the FIFO is treated as empty, so ready reads high.
  assign in_ready = !rst_n || (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Issue uses the pre-edge occupancy, so a set never bypasses the FIFO.
  assign pop      = (count_q != '0) && !hold;

  // Next-state for pointers, occupancy, issued operands and issue counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_set_d   = out_set_q;
    out_issue_d = 1'b0;
    issue_cnt_d = issue_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_set_d   = mem_q[rd_ptr_q];
      out_issue_d = 1'b1;
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_set_q   <= '0;
      out_issue_q <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_set_q   <= out_set_d;
      out_issue_q <= out_issue_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Operand storage; contents are don't-care after reset, only pointers matter.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= in_set;
    end
  end

  // res_valid tracks out_issue through an LAT-deep shift register, ignoring hold.
  generate
    if (LAT == 1) begin : g_res_one
      always_ff @(posedge clk) begin
        if (!rst_n) res_sr_q <= '0;
        else        res_sr_q <= out_issue_q;
      end
    end else begin : g_res_multi
      always_ff @(posedge clk) begin
        if (!rst_n) res_sr_q <= '0;
        else        res_sr_q <= {res_sr_q[LAT-2:0], out_issue_q};
      end
    end
  endgenerate

  assign out_a     = out_set_q.a;
  assign out_b     = out_set_q.b;
  assign out_c     = out_set_q.c;
  assign out_d     = out_set_q.d;
  assign out_issue = out_issue_q;
  assign res_valid = res_sr_q[LAT-1];
  assign count     = count_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pipe_operand_feeder.sv
// Bench for pipe_operand_feeder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_operand_feeder;

  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a, in_b, in_c, in_d;
  logic          hold;
  logic [N-1:0]  out_a, out_b, out_c, out_d;
  logic          out_issue;
  logic          res_valid;
  logic [CW-1:0] count;
  logic [15:0]   issue_cnt;

  int checks = 0;
  int errors = 0;

  pipe_operand_feeder #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .hold(hold),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_issue(out_issue), .res_valid(res_valid),
    .count(count), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4*N-1:0] m_q[$];
  logic [4*N-1:0] m_out;
  bit             m_issue;
  int             m_cnt;
  int             m_edge;
  int             m_issue_edges[$];
  bit             m_ok;

  initial begin
    m_out = '0; m_issue = 0; m_cnt = 0; m_edge = 0; m_ok = 0;
  end

  always @(posedge clk) begin
    bit do_pop, do_push;
    m_edge++;
    if (!rst_n) begin
      m_q.delete();
      m_issue_edges.delete();
      m_out   = '0;
      m_issue = 0;
      m_cnt   = 0;
      m_ok    = 1;
    end else begin
      do_pop  = (m_q.size() != 0) && !hold;
      do_push = in_valid && (m_q.size() < DEPTH);
      m_issue = do_pop;
      if (do_pop) begin
        m_out = m_q.pop_front();
        m_cnt = (m_cnt + 1) % 65536;
        m_issue_edges.push_back(m_edge);
      end
      if (do_push) m_q.push_back({in_a, in_b, in_c, in_d});
    end
    while (m_issue_edges.size() > 0 && m_issue_edges[0] < m_edge - LAT)
      void'(m_issue_edges.pop_front());
  end

  // Compare DUT against model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    bit exp_res;
    if (m_ok) begin
      exp_res = (m_issue_edges.size() > 0) && (m_issue_edges[0] == m_edge - LAT);
      chk("model_count",     64'(count),     64'(m_q.size()));
      chk("model_in_ready",  64'(in_ready),  64'(m_q.size() < DEPTH));
      chk("model_out_issue", 64'(out_issue), 64'(m_issue));
      chk("model_res_valid", 64'(res_valid), 64'(exp_res));
      chk("model_out",       64'({out_a, out_b, out_c, out_d}), 64'(m_out));
      chk("model_issue_cnt", 64'(issue_cnt), 64'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [N-1:0] a, b, c, d);
    in_valid = v; in_a = a; in_b = b; in_c = c; in_d = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    drive(0, '0, '0, '0, '0);
    do_reset();
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_issue", 64'(out_issue), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_issue_cnt", 64'(issue_cnt), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // Single set: push at edge 1, issue at edge 2, result after edge 5.
    drive(1, 10'd10, 10'd12, 10'd6, 10'd1);
    step();
    drive(0, '0, '0, '0, '0);
    chk("single_no_bypass", 64'(out_issue), 64'd0);
    chk("single_count1",    64'(count),     64'd1);
    step();
    chk("single_issue", 64'(out_issue), 64'd1);
    chk("single_out",   64'({out_a, out_b, out_c, out_d}), {24'd0, 10'd10, 10'd12, 10'd6, 10'd1});
    step(); chk("single_res_e3", 64'(res_valid), 64'd0);
    step(); chk("single_res_e4", 64'(res_valid), 64'd0);
    step(); chk("single_res_e5", 64'(res_valid), 64'd1);
    chk("single_out_held", 64'(out_a), 64'd10);
    step(); chk("single_res_e6", 64'(res_valid), 64'd0);

    // Fill with hold: five pushes into four entries, fifth dropped.
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, N'(100 + 10*k), N'(101 + 10*k), N'(102 + 10*k), N'(103 + 10*k));
      step();
      if (k == 3) begin
        chk("fill_count4",  64'(count),    64'd4);
        chk("fill_ready0",  64'(in_ready), 64'd0);
      end
    end
    chk("fill_drop_count", 64'(count), 64'd4);
    drive(0, '0, '0, '0, '0);
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fill_issue",   64'(out_issue), 64'd1);
      chk("fill_order_a", 64'(out_a),     64'(100 + 10*k));
      chk("fill_order_d", 64'(out_d),     64'(103 + 10*k));
    end
    step();
    chk("fill_idle",  64'(out_issue), 64'd0);
    chk("fill_empty", 64'(count),     64'd0);
    chk("fill_held",  64'(out_a),     64'd130);

    // Streaming: eight back-to-back sets from reset.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, N'(200 + k), N'(300 + k), N'(400 + k), N'(500 + k));
      step();
      chk("stream_count_le1", 64'(count <= 1), 64'd1);
      if (k > 0) begin
        chk("stream_issue", 64'(out_issue), 64'd1);
        chk("stream_order", 64'(out_a),     64'(200 + k - 1));
      end
    end
    drive(0, '0, '0, '0, '0);
    step();
    chk("stream_last", 64'(out_b), 64'd307);
    step(); step();
    chk("stream_issue_cnt", 64'(issue_cnt), 64'd8);

    // Simultaneous push and pop at count 2.
    hold = 1'b1;
    drive(1, 10'd21, 10'd22, 10'd23, 10'd24); step();
    drive(1, 10'd31, 10'd32, 10'd33, 10'd34); step();
    chk("pp_count_pre", 64'(count), 64'd2);
    hold = 1'b0;
    drive(1, 10'd41, 10'd42, 10'd43, 10'd44); step();
    drive(0, '0, '0, '0, '0);
    chk("pp_count_same", 64'(count), 64'd2);
    chk("pp_head_out",   64'(out_a), 64'd21);
    step(); chk("pp_second", 64'(out_a), 64'd31);
    step(); chk("pp_tail",   64'(out_a), 64'd41);
    step();

    // Reset mid-stream with count 3 and two sets in flight.
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, N'(600 + k), '0, '0, '0); step();
    end
    hold = 1'b0;
    drive(1, 10'd700, '0, '0, '0); step();
    drive(1, 10'd701, '0, '0, '0); step();
    chk("mid_count3", 64'(count), 64'd3);
    rst_n = 1'b0;
    drive(0, '0, '0, '0, '0);
    step();
    chk("mid_rst_count", 64'(count),     64'd0);
    chk("mid_rst_issue", 64'(out_issue), 64'd0);
    chk("mid_rst_res",   64'(res_valid), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mid_no_stale_res", 64'(res_valid), 64'd0);
    end

    // Issue counter wrap after 65536 issues.
    do_reset();
    for (int k = 0; k < 65536; k++) begin
      drive(1, N'(k), N'(k + 1), N'(k + 2), N'(k + 3));
      step();
    end
    drive(0, '0, '0, '0, '0);
    chk("wrap_pre", 64'(issue_cnt), 64'd65535);
    step();
    chk("wrap_zero", 64'(issue_cnt), 64'd0);
    step(); step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
